csi_sgr_parser: RTL and testbench

- Byte-stream front end of the terminal parser. Consumes raw bytes from the UART receive FIFO and recognises printable characters and ESC [ ... final-byte (CSI) sequences.
- Emits single-cycle commands (commandReady, commandType, Pns) to the SGR graphics-control stage and the text writer.
- Decimal parameters are accumulated here, so downstream only sees 8-bit Pns values.

---
 rtl/DataType.sv | 49 ++++
 rtl/csi_pn_accumulator.sv | 29 ++
 rtl/csi_sgr_parser.sv | 135 +++++++++++++
 tb/tb_csi_sgr_parser.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/DataType.sv
// Shared command, state and byte definitions for the CSI/SGR byte-stream parser.
package DataType;

  typedef enum logic [2:0] {
    INPUT   = 3'd0,
    INIT_PN = 3'd1,
    EMIT_PN = 3'd2,
    SGR     = 3'd3,
    SGR0    = 3'd4
  } CommandsType;

  typedef enum logic [1:0] {
    GROUND,
    ESCAPE,
    CSI_PARAM,
    CSI_IGNORE
  } ParserState;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_CAN      = 8'h18;
  localparam logic [7:0] ASCII_SUB      = 8'h1A;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_SEMI     = 8'h3B;
  localparam logic [7:0] ASCII_M        = 8'h6D;

  localparam int PN_MAX = 255;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

  function automatic logic is_c0(input logic [7:0] b);
    return b < 8'h20;
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_final(input logic [7:0] b);
    return (b >= 8'h40) && (b <= 8'h7E);
  endfunction

  // Bytes that divert a CSI into the ignore state: intermediates and ':' / private markers.
  function automatic logic is_csi_divert(input logic [7:0] b);
    return ((b >= 8'h20) && (b <= 8'h2F)) || ((b >= 8'h3A) && (b <= 8'h3F) && (b != ASCII_SEMI));
  endfunction

endpackage

// File: rtl/csi_pn_accumulator.sv
// Saturating decimal parameter accumulator: value = min(value*10 + digit, PN_MAX).
module csi_pn_accumulator
  import DataType::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  output logic [7:0] value
);

  logic [11:0] w_sum;

  // 255*10 + 9 = 2559 fits in 12 bits, so the sum itself can never wrap.
  assign w_sum = ({4'd0, value} * 12'd10) + {8'd0, digit};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (digit_valid) begin
      value <= (w_sum > 12'(PN_MAX)) ? 8'(PN_MAX) : w_sum[7:0];
    end
  end

endmodule

// File: rtl/csi_sgr_parser.sv
// Byte-stream front end: printable characters and ESC [ ... final CSI sequences into commands.
// Optional idle abort inside a sequence is built only when CSI_PARSER_TIMEOUT_EN is defined.
module csi_sgr_parser
  import DataType::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        commandReady,
  output CommandsType commandType,
  output logic [7:0]  Pns
);

  ParserState r_state;
  logic       r_param_seen;
  logic       w_accept;
  logic       w_digit_valid;
  logic       w_acc_clear;
  logic       w_timeout;
  logic [7:0] w_acc;

  // Stall one cycle after every SGR/SGR0 so downstream gets a command-free commit slot.
  assign in_ready = !(commandReady && ((commandType == SGR) || (commandType == SGR0)));
  assign w_accept = in_valid && in_ready;

  assign w_digit_valid = w_accept && (r_state == CSI_PARAM) && is_digit(in_data);
  assign w_acc_clear   = w_timeout ||
                         (w_accept && (((r_state == ESCAPE) && (in_data == ASCII_LBRACKET)) ||
                                       ((r_state == CSI_PARAM) && (in_data == ASCII_SEMI))));

  csi_pn_accumulator u_acc (
    .clk         (clk),
    .rst         (rst),
    .clear       (w_acc_clear),
    .digit_valid (w_digit_valid),
    .digit       (in_data[3:0]),
    .value       (w_acc)
  );

`ifdef CSI_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] r_idle_cnt;

  assign w_timeout = !w_accept && (r_state != GROUND) && (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (w_accept || (r_state == GROUND)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= GROUND;
      r_param_seen <= 1'b0;
      commandReady <= 1'b0;
      commandType  <= INPUT;
      Pns          <= '0;
    end else begin
      commandReady <= 1'b0;
      if (w_timeout) begin
        r_state <= GROUND;
      end else if (w_accept) begin
        if ((r_state != GROUND) && ((in_data == ASCII_CAN) || (in_data == ASCII_SUB))) begin
          r_state <= GROUND;
        end else if (in_data == ASCII_ESC) begin
          r_state <= ESCAPE;
        end else if ((r_state == GROUND) || !is_c0(in_data)) begin
          // Remaining C0 bytes inside a sequence fall through here untouched.
          case (r_state)
            GROUND: begin
              if (is_printable(in_data)) begin
                commandReady <= 1'b1;
                commandType  <= INPUT;
                Pns          <= in_data;
              end
            end
            ESCAPE: begin
              if (in_data == ASCII_LBRACKET) begin
                r_state      <= CSI_PARAM;
                r_param_seen <= 1'b0;
                commandReady <= 1'b1;
                commandType  <= INIT_PN;
                Pns          <= '0;
              end else begin
                r_state <= GROUND;
              end
            end
            CSI_PARAM: begin
              if (is_digit(in_data)) begin
                r_param_seen <= 1'b1;
              end else if (in_data == ASCII_SEMI) begin
                r_param_seen <= 1'b1;
                commandReady <= 1'b1;
                commandType  <= EMIT_PN;
                Pns          <= w_acc;
              end else if (in_data == ASCII_M) begin
                r_state      <= GROUND;
                commandReady <= 1'b1;
                commandType  <= r_param_seen ? SGR : SGR0;
                Pns          <= r_param_seen ? w_acc : 8'd0;
              end else if (is_csi_divert(in_data)) begin
                r_state <= CSI_IGNORE;
              end else if (is_final(in_data)) begin
                r_state <= GROUND;
              end
            end
            CSI_IGNORE: begin
              if (is_final(in_data)) begin
                r_state <= GROUND;
              end
            end
            default: r_state <= GROUND;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_csi_sgr_parser.sv
// Scoreboard bench for csi_sgr_parser: directed sequences plus random bytes against a text-level model.
module tb_csi_sgr_parser;
  import DataType::*;

  typedef struct {
    CommandsType t;
    logic [7:0]  pn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        commandReady;
  CommandsType commandType;
  logic [7:0]  Pns;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   prev_sgr = 1'b0;

  // Reference model: "inside ESC", "inside CSI parameters", "skipping a CSI", digits of the open field.
  bit   m_esc, m_csi, m_skip, m_seen;
  int   m_digs[$];

  csi_sgr_parser #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .commandReady (commandReady),
    .commandType  (commandType),
    .Pns          (Pns)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_exp(input CommandsType t, input int pn);
    exp_t e;
    e.t  = t;
    e.pn = 8'(pn);
    exp_q.push_back(e);
  endfunction

  function automatic int field_value();
    int v = 0;
    foreach (m_digs[i]) begin
      v = v * 10 + m_digs[i];
      if (v > 100000) v = 100000;
    end
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void model_clear();
    m_esc  = 1'b0;
    m_csi  = 1'b0;
    m_skip = 1'b0;
    m_seen = 1'b0;
    m_digs.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit fin = (b >= 8'h40) && (b <= 8'h7E);
    if (!m_esc && !m_csi && !m_skip) begin
      if (b == 8'h1B) m_esc = 1'b1;
      else if ((b >= 8'h20) && (b <= 8'h7E)) push_exp(INPUT, int'(b));
      return;
    end
    if ((b == 8'h18) || (b == 8'h1A)) begin
      model_clear();
      return;
    end
    if (b == 8'h1B) begin
      model_clear();
      m_esc = 1'b1;
      return;
    end
    if (b < 8'h20) return;
    if (m_esc) begin
      m_esc = 1'b0;
      if (b == 8'h5B) begin
        m_csi  = 1'b1;
        m_seen = 1'b0;
        m_digs.delete();
        push_exp(INIT_PN, 0);
      end
    end else if (m_skip) begin
      if (fin) m_skip = 1'b0;
    end else begin
      if ((b >= 8'h30) && (b <= 8'h39)) begin
        m_digs.push_back(int'(b) - 48);
        m_seen = 1'b1;
      end else if (b == 8'h3B) begin
        push_exp(EMIT_PN, field_value());
        m_digs.delete();
        m_seen = 1'b1;
      end else if (b == 8'h6D) begin
        if (m_seen) push_exp(SGR, field_value());
        else push_exp(SGR0, 0);
        m_csi = 1'b0;
      end else if (((b >= 8'h20) && (b <= 8'h2F)) || ((b >= 8'h3A) && (b <= 8'h3F))) begin
        m_csi  = 1'b0;
        m_skip = 1'b1;
      end else if (fin) begin
        m_csi = 1'b0;
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int budget = 20;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      check("accept_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 19))
      0, 1, 2, 3: return 8'h30 + 8'($urandom_range(0, 9));
      4, 5:       return 8'h3B;
      6, 7:       return 8'h6D;
      8, 9:       return 8'h1B;
      10, 11:     return 8'h5B;
      12:         return $urandom_range(0, 1) ? 8'h18 : 8'h1A;
      13:         return 8'h3C + 8'($urandom_range(0, 3));
      14:         return 8'h20 + 8'($urandom_range(0, 15));
      15:         return 8'($urandom_range(0, 31));
      16:         return 8'h40 + 8'($urandom_range(0, 62));
      default:    return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // Monitor: pop one expectation per strobe, and require a quiet cycle after SGR/SGR0.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_sgr) check("gap_after_sgr", 32'(commandReady), 32'd0);
      prev_sgr = 1'b0;
      if (commandReady) begin
        if (exp_q.size() == 0) begin
          check("spurious_cmd", 32'(commandType), 32'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd_type", 32'(commandType), 32'(mon_e.t));
          check("cmd_pns", 32'(Pns), 32'(mon_e.pn));
          prev_sgr = (mon_e.t == SGR) || (mon_e.t == SGR0);
          check("in_ready_in_cmd", 32'(in_ready), prev_sgr ? 32'd0 : 32'd1);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    #2;
    check("rst_ready", 32'(commandReady), 32'd0);
    check("rst_type", 32'(commandType), 32'(INPUT));
    check("rst_pns", 32'(Pns), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    send_str("A");
    send_str({8'h1B, "[1;31m"});
    send_str({8'h1B, "[m"});
    send_str({8'h1B, "[1;m"});
    send_str({8'h1B, "[38;2;300;128;0m"});
    send_str({8'h1B, "[?25hB"});
    send_str({8'h1B, "[1", 8'h18, "C"});
    send_str({8'h1B, 8'h1B, "[7", 8'h07, "m"});

    // Asynchronous reset while an EMIT_PN strobe is still on the outputs.
    send_str({8'h1B, "[1;"});
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(commandReady), 32'd0);
    check("mid_rst_type", 32'(commandType), 32'(INPUT));
    check("mid_rst_pns", 32'(Pns), 32'd0);
    exp_q.delete();
    prev_sgr = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1);
    send_str("D");

`ifdef CSI_PARSER_TIMEOUT_EN
    send_str({8'h1B, "[4"});
    idle(10);
    model_clear();
    send_str("m");
`endif

    for (int n = 0; n < 1500; n++) begin
      send_byte(rand_byte());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
